packet_router: RTL and testbench
================================

Name: packet_router

Overview:
- Parametrised NUM_PORTS x NUM_PORTS wormhole packet router for the packet_controller subsystem.
- Each input buffers flits in a FIFO and decodes the destination port from the head flit.
- Each output has a round-robin arbiter that locks to one input for a whole packet.
- Packets with an illegal destination, and stray body/tail flits, are dropped and counted.

Parameters:
NUM_PORTS, 4, number of input ports and of output ports (2..8)
FLIT_WIDTH, 32, flit width in bits, including 2-bit type field
FIFO_DEPTH, 4, per-input FIFO depth in flits (power of 2, >=2)
DEST_WIDTH, 3, width of destination field in head flit (>= clog2(NUM_PORTS))
CNT_WIDTH, 16, width of drop counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  NUM_PORTS  per-input flit valid
in_ready  output  NUM_PORTS  per-input ready
in_flit  input  NUM_PORTS*FLIT_WIDTH  packed input flits, port i at [i*FLIT_WIDTH +: FLIT_WIDTH]
out_valid  output  NUM_PORTS  per-output flit valid
out_ready  input  NUM_PORTS  per-output downstream ready
out_flit  output  NUM_PORTS*FLIT_WIDTH  packed output flits, same packing as in_flit
drop_count  output  CNT_WIDTH  saturating count of dropped packets and stray flits
busy  output  1  any FIFO non-empty or any output locked

Behaviour:
- Flit type field is bits [FLIT_WIDTH-1:FLIT_WIDTH-2]:
  - 2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 HEADTAIL.
  - Head destination is bits [FLIT_WIDTH-3 -: DEST_WIDTH].
- Handshakes: transfer occurs when valid&&ready at a rising edge. in_ready[i] = !full[i]; there is no push-when-full bypass. out_valid must not depend combinationally on out_ready.
- Reset (rst=1 at edge):
  - FIFOs flushed, all locks cleared, drop state cleared.
  - RR pointers = 0, drop_count = 0.
  - After the edge: out_valid = 0, in_ready = all 1, busy = 0, out_flit = 0.
  - Reset mid-packet discards partial packets; no tail is emitted.
- Latency: flit pushed at edge t is visible at FIFO head and may appear on out_flit/out_valid in cycle t+1. out_flit is driven combinationally from the granted FIFO head. Throughput is 1 flit/cycle per output.
- Per-input state: IDLE, FWD(o), DROP.
  - IDLE, head is HEAD/HEADTAIL with dest < NUM_PORTS: the input requests output dest.
  - IDLE, head is HEAD/HEADTAIL with dest >= NUM_PORTS: pop 1/cycle without forwarding; drop_count += 1 when the head is popped. HEAD goes to DROP; HEADTAIL stays IDLE.
  - IDLE, head is BODY/TAIL (stray): pop and discard, drop_count += 1, stay IDLE.
  - FWD(o): every head flit is forwarded to output o regardless of type. TAIL transfer goes to IDLE.
  - DROP: pop every cycle; TAIL pop goes to IDLE; no further count.
- Per-output arbiter:
  - Unlocked: grant the first requesting input scanning from rr_ptr upward, with wrap.
  - Grant and transfer may happen in the same cycle the request appears.
  - On a HEAD transfer: lock output to that input (input enters FWD(o)) and set rr_ptr = (grant+1) mod NUM_PORTS.
  - HEADTAIL transfer: no lock; rr_ptr updates the same way.
  - Locked: only the owning input is served; other requesters wait with FIFO contents unchanged. Lock releases on the edge the TAIL transfers; a new grant is possible in the following cycle.
  - Owning FIFO empty while locked: out_valid = 0, lock held.
  - out_ready low: out_valid and out_flit held stable, no pop.
- drop_count saturates at all-ones. Multiple drops in one cycle add their sum, saturating.
- Simultaneous push and pop on the same FIFO: both occur and occupancy is unchanged. A full FIFO can pop and still reports in_ready = 0 that cycle.

Test Plan:
- Reset, then input 0 sends HEADTAIL with dest=2, payload 0x0ABC -> out_valid[2]=1 one cycle after acceptance with identical flit; other out_valid=0; drop_count=0.
- Inputs 1 and 3 send simultaneous 3-flit packets (HEAD, BODY, TAIL) to output 0, out_ready=1 -> input 1's three flits contiguous on out 0, then input 3's three, with no interleaving; rr_ptr ends at 0.
- Input 2 sends HEAD dest=7 (NUM_PORTS=4), BODY, TAIL -> no out_valid on any port, drop_count=1, FIFO drains in 3 cycles, busy returns 0.
- Input 0 sends 6 flits with out_ready[1]=0 and FIFO_DEPTH=4 -> in_ready[0]=0 after 4 accepted; raising out_ready releases all 6 in order; out_flit is stable while stalled.
- Stray BODY on input 1 while idle -> discarded, drop_count=1; next HEADTAIL on input 1 is forwarded normally.
- Assert rst mid-packet (after HEAD and BODY forwarded on output 3) -> next cycle out_valid=0, busy=0, drop_count=0; a fresh packet from another input is granted output 3 immediately.

Source files
------------

// File: rtl/packet_router.sv
// NUM_PORTS x NUM_PORTS wormhole router: per-input flit FIFOs, per-output
// round-robin arbiters that hold a grant for a whole packet, and a drop counter.
module packet_router #(
  parameter int NUM_PORTS  = 4,
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int DEST_WIDTH = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  output logic [NUM_PORTS-1:0]            in_ready,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0] in_flit,
  output logic [NUM_PORTS-1:0]            out_valid,
  input  logic [NUM_PORTS-1:0]            out_ready,
  output logic [NUM_PORTS*FLIT_WIDTH-1:0] out_flit,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic                            busy
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] T_HEAD     = 2'b01;
  localparam logic [1:0] T_TAIL     = 2'b10;
  localparam logic [1:0] T_HEADTAIL = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} in_state_e;

  logic [FLIT_WIDTH-1:0] mem_q [NUM_PORTS][FIFO_DEPTH];
  logic [AW-1:0]         rd_q  [NUM_PORTS];
  logic [AW-1:0]         wr_q  [NUM_PORTS];
  logic [AW:0]           cnt_q [NUM_PORTS];
  in_state_e             st_q  [NUM_PORTS];
  in_state_e             st_d  [NUM_PORTS];
  logic [PW-1:0]         owner_q [NUM_PORTS];
  logic [PW-1:0]         owner_d [NUM_PORTS];
  logic [PW-1:0]         rr_q  [NUM_PORTS];
  logic [PW-1:0]         rr_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0]  lock_q, lock_d;
  logic [CNT_WIDTH-1:0]  drop_q, drop_d;

  logic [FLIT_WIDTH-1:0] head  [NUM_PORTS];
  logic [1:0]            htype [NUM_PORTS];
  logic [DEST_WIDTH-1:0] dest  [NUM_PORTS];
  logic [PW-1:0]         gnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0]  legal, nonempty, push, pop;
  logic [CNT_WIDTH:0]    inc, sum;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      head[i]     = mem_q[i][rd_q[i]];
      htype[i]    = head[i][FLIT_WIDTH-1 -: 2];
      dest[i]     = head[i][FLIT_WIDTH-3 -: DEST_WIDTH];
      legal[i]    = int'(dest[i]) < NUM_PORTS;
      nonempty[i] = cnt_q[i] != '0;
      in_ready[i] = cnt_q[i] != (AW+1)'(FIFO_DEPTH);
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // A locked output serves only its owner; otherwise scan idle heads from rr_q.
  always_comb begin
    int idx;
    idx       = 0;
    out_valid = '0;
    out_flit  = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      gnt[o] = '0;
      if (lock_q[o]) begin
        gnt[o]       = owner_q[o];
        out_valid[o] = nonempty[owner_q[o]];
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          idx = (int'(rr_q[o]) + k) % NUM_PORTS;
          if (!out_valid[o] && st_q[idx] == ST_IDLE && nonempty[idx] &&
              htype[idx][0] && legal[idx] && int'(dest[idx]) == o) begin
            out_valid[o] = 1'b1;
            gnt[o]       = PW'(idx);
          end
        end
      end
      if (out_valid[o]) out_flit[o*FLIT_WIDTH +: FLIT_WIDTH] = head[gnt[o]];
    end
  end

  always_comb begin
    pop     = '0;
    st_d    = st_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    inc     = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (out_valid[o] && out_ready[o]) begin
        pop[gnt[o]] = 1'b1;
        case (htype[gnt[o]])
          T_HEAD: if (!lock_q[o]) begin
            lock_d[o]       = 1'b1;
            owner_d[o]      = gnt[o];
            rr_d[o]         = PW'((int'(gnt[o]) + 1) % NUM_PORTS);
            st_d[gnt[o]]    = ST_FWD;
          end
          T_HEADTAIL: if (!lock_q[o]) rr_d[o] = PW'((int'(gnt[o]) + 1) % NUM_PORTS);
          T_TAIL: if (lock_q[o]) begin
            lock_d[o]    = 1'b0;
            st_d[gnt[o]] = ST_IDLE;
          end
          default: ;
        endcase
      end
    end
    // Illegal heads and stray body/tail flits are counted once, at the head pop.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (nonempty[i]) begin
        if (st_q[i] == ST_IDLE && (!htype[i][0] || !legal[i])) begin
          pop[i] = 1'b1;
          inc    = inc + (CNT_WIDTH+1)'(1);
          if (htype[i] == T_HEAD) st_d[i] = ST_DROP;
        end else if (st_q[i] == ST_DROP) begin
          pop[i] = 1'b1;
          if (htype[i] == T_TAIL) st_d[i] = ST_IDLE;
        end
      end
    end
    sum    = {1'b0, drop_q} + inc;
    drop_d = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_q[i]    <= '0;
        wr_q[i]    <= '0;
        cnt_q[i]   <= '0;
        st_q[i]    <= ST_IDLE;
        owner_q[i] <= '0;
        rr_q[i]    <= '0;
      end
      lock_q <= '0;
      drop_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        rd_q[i]    <= rd_q[i] + AW'(pop[i]);
        wr_q[i]    <= wr_q[i] + AW'(push[i]);
        cnt_q[i]   <= cnt_q[i] + (AW+1)'(push[i]) - (AW+1)'(pop[i]);
        st_q[i]    <= st_d[i];
        owner_q[i] <= owner_d[i];
        rr_q[i]    <= rr_d[i];
      end
      lock_q <= lock_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push[i]) mem_q[i][wr_q[i]] <= in_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  assign drop_count = drop_q;
  assign busy       = (|nonempty) || (|lock_q);

endmodule

// File: tb/tb_packet_router.sv
// Directed bench for packet_router (4 ports, 32-bit flits, depth-4 FIFOs):
// a per-cycle vector table plus hand sequences for stall and mid-packet reset.
module tb_packet_router;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_flit, out_flit;
  logic [15:0]  drop_count;
  logic         busy;

  int checks = 0;
  int errors = 0;

  packet_router dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  iv;
    logic [127:0] fl;
    logic [3:0]  e_ov;
    int          e_port;
    logic [31:0] e_flit;
    logic [15:0] e_drop;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];
  logic [31:0] exp_q[$];

  function automatic logic [31:0] fl(input logic [1:0] t, input logic [2:0] d, input logic [26:0] p);
    return {t, d, p};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [3:0] iv,
                               input logic [31:0] f0, input logic [31:0] f1,
                               input logic [31:0] f2, input logic [31:0] f3,
                               input logic [3:0] eov, input int ep, input logic [31:0] ef,
                               input logic [15:0] ed, input logic eb);
    vec_t v;
    v.nm = nm; v.iv = iv; v.fl = {f3, f2, f1, f0};
    v.e_ov = eov; v.e_port = ep; v.e_flit = ef; v.e_drop = ed; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    in_valid  = v.iv;
    in_flit   = v.fl;
    out_ready = 4'hF;
    @(negedge clk);
    chk({v.nm, ".out_valid"}, 128'(out_valid), 128'(v.e_ov));
    chk({v.nm, ".in_ready"}, 128'(in_ready), 128'(4'hF));
    chk({v.nm, ".drop_count"}, 128'(drop_count), 128'(v.e_drop));
    chk({v.nm, ".busy"}, 128'(busy), 128'(v.e_busy));
    chk({v.nm, ".out_flit"}, 128'(out_flit[v.e_port*32 +: 32]), 128'(v.e_flit));
    @(posedge clk); #1;
  endtask

  logic [31:0] z, ht02, h10, b11, t12, h30, b31, t32, h27, b2, t2, sb, ht13;
  logic [31:0] sfl [6];
  logic [31:0] rh, rb, rt, ht0, ht2, got;
  int sent;

  initial begin
    z    = '0;
    ht02 = fl(2'b11, 3'd2, 27'h0ABC);
    h10  = fl(2'b01, 3'd0, 27'h11);
    b11  = fl(2'b00, 3'd0, 27'h12);
    t12  = fl(2'b10, 3'd0, 27'h13);
    h30  = fl(2'b01, 3'd0, 27'h31);
    b31  = fl(2'b00, 3'd0, 27'h32);
    t32  = fl(2'b10, 3'd0, 27'h33);
    h27  = fl(2'b01, 3'd7, 27'h21);
    b2   = fl(2'b00, 3'd0, 27'h22);
    t2   = fl(2'b10, 3'd0, 27'h23);
    sb   = fl(2'b00, 3'd0, 27'h55);
    ht13 = fl(2'b11, 3'd3, 27'h66);

    //                name          iv       f0    f1    f2    f3    e_ov     port e_flit e_drop busy
    tbl.push_back(mkv("ht_push",    4'b0001, ht02, z,    z,    z,    4'b0000, 2, z,    16'd0, 1'b0));
    tbl.push_back(mkv("ht_out",     4'b0000, z,    z,    z,    z,    4'b0100, 2, ht02, 16'd0, 1'b1));
    tbl.push_back(mkv("ht_done",    4'b0000, z,    z,    z,    z,    4'b0000, 2, z,    16'd0, 1'b0));
    tbl.push_back(mkv("rr_push",    4'b1010, z,    h10,  z,    h30,  4'b0000, 0, z,    16'd0, 1'b0));
    tbl.push_back(mkv("rr_h1",      4'b1010, z,    b11,  z,    b31,  4'b0001, 0, h10,  16'd0, 1'b1));
    tbl.push_back(mkv("rr_b1",      4'b1010, z,    t12,  z,    t32,  4'b0001, 0, b11,  16'd0, 1'b1));
    tbl.push_back(mkv("rr_t1",      4'b0000, z,    z,    z,    z,    4'b0001, 0, t12,  16'd0, 1'b1));
    tbl.push_back(mkv("rr_h3",      4'b0000, z,    z,    z,    z,    4'b0001, 0, h30,  16'd0, 1'b1));
    tbl.push_back(mkv("rr_b3",      4'b0000, z,    z,    z,    z,    4'b0001, 0, b31,  16'd0, 1'b1));
    tbl.push_back(mkv("rr_t3",      4'b0000, z,    z,    z,    z,    4'b0001, 0, t32,  16'd0, 1'b1));
    tbl.push_back(mkv("rr_done",    4'b0000, z,    z,    z,    z,    4'b0000, 0, z,    16'd0, 1'b0));
    tbl.push_back(mkv("drop_h",     4'b0100, z,    z,    h27,  z,    4'b0000, 2, z,    16'd0, 1'b0));
    tbl.push_back(mkv("drop_b",     4'b0100, z,    z,    b2,   z,    4'b0000, 2, z,    16'd0, 1'b1));
    tbl.push_back(mkv("drop_t",     4'b0100, z,    z,    t2,   z,    4'b0000, 2, z,    16'd1, 1'b1));
    tbl.push_back(mkv("drop_drain", 4'b0000, z,    z,    z,    z,    4'b0000, 2, z,    16'd1, 1'b1));
    tbl.push_back(mkv("drop_idle",  4'b0000, z,    z,    z,    z,    4'b0000, 2, z,    16'd1, 1'b0));
    tbl.push_back(mkv("stray_push", 4'b0010, z,    sb,   z,    z,    4'b0000, 3, z,    16'd1, 1'b0));
    tbl.push_back(mkv("stray_ht",   4'b0010, z,    ht13, z,    z,    4'b0000, 3, z,    16'd1, 1'b1));
    tbl.push_back(mkv("stray_fwd",  4'b0000, z,    z,    z,    z,    4'b1000, 3, ht13, 16'd2, 1'b1));
    tbl.push_back(mkv("stray_done", 4'b0000, z,    z,    z,    z,    4'b0000, 3, z,    16'd2, 1'b0));

    // Reset
    rst = 1'b1; in_valid = '0; in_flit = '0; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.out_valid", 128'(out_valid), 128'(4'h0));
    chk("reset.in_ready", 128'(in_ready), 128'(4'hF));
    chk("reset.busy", 128'(busy), 128'(1'b0));
    chk("reset.drop_count", 128'(drop_count), 128'(16'd0));
    chk("reset.out_flit", out_flit, 128'(0));
    @(posedge clk); #1;

    for (int n = 0; n < tbl.size(); n++) run_vec(tbl[n]);

    // Backpressure: six flits into a depth-4 FIFO while output 1 is stalled.
    sfl[0] = fl(2'b01, 3'd1, 27'h40);
    for (int k = 1; k < 5; k++) sfl[k] = fl(2'b00, 3'd0, 27'(32'h40 + k));
    sfl[5] = fl(2'b10, 3'd0, 27'h45);
    for (int k = 0; k < 6; k++) exp_q.push_back(sfl[k]);
    sent = 0;
    for (int cyc = 0; cyc < 40 && (sent < 6 || exp_q.size() > 0); cyc++) begin
      in_valid  = (sent < 6) ? 4'b0001 : 4'b0000;
      in_flit   = 128'(sfl[(sent < 6) ? sent : 0]);
      out_ready = (cyc >= 8) ? 4'hF : 4'b1101;
      @(negedge clk);
      if (cyc >= 4 && cyc < 8) begin
        chk("stall.in_ready0", 128'(in_ready[0]), 128'(1'b0));
        chk("stall.out_valid1", 128'(out_valid[1]), 128'(1'b1));
        chk("stall.out_flit1", 128'(out_flit[63:32]), 128'(sfl[0]));
      end
      if (out_valid[1] && out_ready[1]) begin
        got = out_flit[63:32];
        if (exp_q.size() == 0) chk("stall.extra_flit", 128'(got), 128'(0));
        else chk("stall.order", 128'(got), 128'(exp_q.pop_front()));
      end
      if (in_valid[0] && in_ready[0]) sent++;
      @(posedge clk); #1;
    end
    in_valid = '0;
    chk("stall.all_sent", 128'(sent), 128'(6));
    chk("stall.all_received", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    chk("stall.busy_after", 128'(busy), 128'(1'b0));
    @(posedge clk); #1;

    // Reset in the middle of a packet on output 3.
    rh  = fl(2'b01, 3'd3, 27'h70);
    rb  = fl(2'b00, 3'd0, 27'h71);
    rt  = fl(2'b10, 3'd0, 27'h72);
    ht0 = fl(2'b11, 3'd3, 27'h80);
    ht2 = fl(2'b11, 3'd3, 27'h82);
    in_valid = 4'b0001; in_flit = 128'(rh);
    @(posedge clk); #1;
    in_valid = 4'b0001; in_flit = 128'(rb);
    @(negedge clk);
    chk("rstmid.head_valid", 128'(out_valid), 128'(4'b1000));
    chk("rstmid.head_flit", 128'(out_flit[127:96]), 128'(rh));
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    chk("rstmid.body_flit", 128'(out_flit[127:96]), 128'(rb));
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 4'b0001; in_flit = 128'(rt);
    @(negedge clk);
    chk("rstmid.busy_locked", 128'(busy), 128'(1'b1));
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 4'b0101; in_flit = {32'h0, ht2, 32'h0, ht0};
    @(negedge clk);
    chk("rstmid.out_valid", 128'(out_valid), 128'(4'h0));
    chk("rstmid.busy", 128'(busy), 128'(1'b0));
    chk("rstmid.drop_count", 128'(drop_count), 128'(16'd0));
    chk("rstmid.in_ready", 128'(in_ready), 128'(4'hF));
    chk("rstmid.out_flit", out_flit, 128'(0));
    @(posedge clk); #1;
    in_valid = '0;
    @(negedge clk);
    chk("rstmid.grant_in0_valid", 128'(out_valid), 128'(4'b1000));
    chk("rstmid.grant_in0_flit", 128'(out_flit[127:96]), 128'(ht0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.grant_in2_flit", 128'(out_flit[127:96]), 128'(ht2));
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid.idle_valid", 128'(out_valid), 128'(4'h0));
    chk("rstmid.idle_busy", 128'(busy), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
